// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared constants for the RV32I fetch-PC sequencer slice.
//   PC_W             : architectural PC width
//   S_BOOT/S_RUN/... : sequencer state encodings
//   DEF_RESET_PC     : default first fetch address after reset
//   DEF_TRAP_VECTOR  : default misaligned-target trap address
//   PC_INC           : sequential fetch increment
// ---------------------------------------------------------------------------
package core_pkg;

   localparam int PC_W = 32;

   typedef logic [1:0] seq_state_t;

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [PC_W-1:0] DEF_RESET_PC    = 32'h0000_0000;
   localparam logic [PC_W-1:0] DEF_TRAP_VECTOR = 32'h0000_0100;
   localparam logic [PC_W-1:0] PC_INC          = 32'd4;

endpackage

// File: rtl/pc_redirect_arb.sv
// ---------------------------------------------------------------------------
// pc_redirect_arb
// Combinational redirect arbiter: picks the execute-stage redirect over a
// decode-stage JAL, forms the JAL target and flags misaligned targets.
//   ex_redir_valid / ex_target : execute redirect request and target
//   id_jal_valid               : decode holds a JAL
//   jal_en                     : JAL may be taken this cycle (no stall, and
//                                decode is on the correct path)
//   id_pc / id_imm             : JAL PC and sign-extended J-immediate
//   redir_valid                : some redirect is selected
//   redir_target               : raw selected target (not yet aligned)
//   redir_is_ex                : the selected redirect came from execute
//   redir_misaligned           : selected target has bits[1:0] != 0
// ---------------------------------------------------------------------------
module pc_redirect_arb
   import core_pkg::*;
(
   input  logic            ex_redir_valid,
   input  logic [PC_W-1:0] ex_target,
   input  logic            id_jal_valid,
   input  logic            jal_en,
   input  logic [PC_W-1:0] id_pc,
   input  logic [PC_W-1:0] id_imm,
   output logic            redir_valid,
   output logic [PC_W-1:0] redir_target,
   output logic            redir_is_ex,
   output logic            redir_misaligned
);

   logic signed [PC_W-1:0] pc_s;
   logic signed [PC_W-1:0] imm_s;
   logic signed [PC_W-1:0] sum_s;
   logic        [PC_W-1:0] jal_target;

   // Two's-complement add: the carry out is simply dropped, giving the
   // required modulo-2^32 wraparound for backward and forward jumps alike.
   assign pc_s       = signed'(id_pc);
   assign imm_s      = signed'(id_imm);
   assign sum_s      = pc_s + imm_s;
   assign jal_target = unsigned'(sum_s);

   always_comb begin
      redir_valid  = 1'b0;
      redir_is_ex  = 1'b0;
      redir_target = ex_target;
      if (ex_redir_valid) begin
         redir_valid  = 1'b1;
         redir_is_ex  = 1'b1;
         redir_target = ex_target;
      end else if (id_jal_valid && jal_en) begin
         redir_valid  = 1'b1;
         redir_target = jal_target;
      end
   end

   assign redir_misaligned = redir_valid && (redir_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_redirect_sequencer.sv
// ---------------------------------------------------------------------------
// pc_redirect_sequencer
// Owns the RV32I fetch PC. Sequences PC+4, takes execute redirects and
// decode JALs, drives the fetch valid/ready request, and raises IF/ID and
// ID/EX flushes. A redirect that arrives while fetch is not accepting the
// current address is parked in pending_pc (S_HOLD) until fetch accepts.
//
// Optional feature: define MISALIGN_TRAP_EN to replace a misaligned target
// with TRAP_VECTOR and pulse misalign_trap; otherwise bits[1:0] of loaded
// targets are cleared and misalign_trap is tied low.
//
// Ports:
//   clk, rst_n      : core clock, asynchronous active-low reset
//   if_pc, if_valid : fetch address and request valid
//   if_ready        : fetch accepts if_pc this cycle
//   stall           : hazard stall (hold PC, ignore decode JAL)
//   id_jal_valid, id_pc, id_imm : decode-stage JAL
//   ex_redir_valid, ex_target   : execute-stage redirect
//   flush_if, flush_id          : kill IF/ID and ID/EX this cycle
//   misalign_trap               : one-cycle misaligned-target trap pulse
// ---------------------------------------------------------------------------
module pc_redirect_sequencer
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
   parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
)(
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] if_pc,
   output logic        if_valid,
   input  logic        if_ready,
   input  logic        stall,
   input  logic        id_jal_valid,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_imm,
   input  logic        ex_redir_valid,
   input  logic [31:0] ex_target,
   output logic        flush_if,
   output logic        flush_id,
   output logic        misalign_trap
);

   seq_state_t      state;
   seq_state_t      state_nxt;
   logic [PC_W-1:0] pending_pc;
   logic [PC_W-1:0] pending_nxt;
   logic [PC_W-1:0] pc_nxt;

   logic            redir_valid;
   logic [PC_W-1:0] redir_target;
   logic            redir_is_ex;
   logic            redir_misaligned;
   logic            jal_en;

   logic            trap_sel;
   logic [PC_W-1:0] trap_pc;
   logic [PC_W-1:0] load_pc;

   logic            flush_if_c;
   logic            flush_id_c;
   logic            trap_c;

   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] t);
      return t & ~32'h0000_0003;
   endfunction

   // A JAL only counts while running and unstalled; in S_HOLD decode holds
   // wrong-path instructions behind the parked redirect.
   assign jal_en = !stall && (state == S_RUN);

   pc_redirect_arb u_arb (
      .ex_redir_valid   (ex_redir_valid),
      .ex_target        (ex_target),
      .id_jal_valid     (id_jal_valid),
      .jal_en           (jal_en),
      .id_pc            (id_pc),
      .id_imm           (id_imm),
      .redir_valid      (redir_valid),
      .redir_target     (redir_target),
      .redir_is_ex      (redir_is_ex),
      .redir_misaligned (redir_misaligned)
   );

   assign trap_pc = TRAP_VECTOR;

`ifdef MISALIGN_TRAP_EN
   assign trap_sel = redir_misaligned;
`else
   logic unused_trap_path;
   assign trap_sel         = 1'b0;
   assign unused_trap_path = ^{redir_misaligned, trap_pc};
`endif

   assign load_pc = trap_sel ? trap_pc : align_pc(redir_target);

   always_comb begin
      state_nxt   = state;
      pc_nxt      = if_pc;
      pending_nxt = pending_pc;
      flush_if_c  = 1'b0;
      flush_id_c  = 1'b0;
      trap_c      = 1'b0;
      case (state)
         S_BOOT: begin
            state_nxt = S_RUN;
         end
         S_RUN: begin
            if (redir_valid) begin
               // The redirect is taken now even if fetch is busy: flush
               // immediately so wrong-path work cannot advance meanwhile.
               flush_if_c = 1'b1;
               flush_id_c = redir_is_ex || trap_sel;
               trap_c     = trap_sel;
               if (if_ready) begin
                  pc_nxt = load_pc;
               end else begin
                  pending_nxt = load_pc;
                  state_nxt   = S_HOLD;
               end
            end else if (if_ready && !stall) begin
               pc_nxt = if_pc + PC_INC;
            end
         end
         S_HOLD: begin
            if (redir_valid) begin
               // Only an execute redirect can be selected here.
               flush_if_c = 1'b1;
               flush_id_c = 1'b1;
               trap_c     = trap_sel;
               if (if_ready) begin
                  pc_nxt    = load_pc;
                  state_nxt = S_RUN;
               end else begin
                  pending_nxt = load_pc;
               end
            end else if (if_ready) begin
               // The word fetched at the old if_pc is stale: drop it.
               pc_nxt     = pending_pc;
               flush_if_c = 1'b1;
               state_nxt  = S_RUN;
            end
         end
         default: begin
            state_nxt = S_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_BOOT;
         if_pc      <= RESET_PC;
         pending_pc <= '0;
      end else begin
         state      <= state_nxt;
         if_pc      <= pc_nxt;
         pending_pc <= pending_nxt;
      end
   end

   assign if_valid      = (state != S_BOOT);
   assign flush_if      = flush_if_c;
   assign flush_id      = flush_id_c;
   assign misalign_trap = trap_c;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
module tb_pc_redirect_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] TRAPV  = 32'h0000_0100;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        if_ready;
   logic        stall;
   logic        id_jal_valid;
   logic [31:0] id_pc;
   logic [31:0] id_imm;
   logic        ex_redir_valid;
   logic [31:0] ex_target;
   logic        flush_if;
   logic        flush_id;
   logic        misalign_trap;

   int checks = 0;
   int errors = 0;

   pc_redirect_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_pc          (if_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .stall          (stall),
      .id_jal_valid   (id_jal_valid),
      .id_pc          (id_pc),
      .id_imm         (id_imm),
      .ex_redir_valid (ex_redir_valid),
      .ex_target      (ex_target),
      .flush_if       (flush_if),
      .flush_id       (flush_id),
      .misalign_trap  (misalign_trap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: the fetch PC, a "booting" flag and a queue holding
   // at most one parked redirect target. Evaluated at each negedge with
   // the inputs that will be sampled on the following posedge.
   // ------------------------------------------------------------------
   bit          m_boot = 1'b1;
   logic [31:0] m_pc   = RST_PC;
   logic [31:0] m_pend[$];

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_boot = 1'b1;
            m_pc   = RST_PC;
            m_pend.delete();
            chk("m_rst_valid", {31'd0, if_valid}, 32'd0);
            chk("m_rst_pc", if_pc, RST_PC);
            chk("m_rst_flush", {30'd0, flush_if, flush_id}, 32'd0);
            chk("m_rst_trap", {31'd0, misalign_trap}, 32'd0);
         end else begin
            logic        e_fif, e_fid, e_trap, have, is_ex;
            logic [31:0] tgt;
            e_fif = 0; e_fid = 0; e_trap = 0; have = 0; is_ex = 0; tgt = '0;
            chk("m_valid", {31'd0, if_valid}, {31'd0, !m_boot});
            chk("m_pc", if_pc, m_pc);
            if (m_boot) begin
               m_boot = 1'b0;
            end else begin
               if (ex_redir_valid) begin
                  have = 1; is_ex = 1; tgt = ex_target;
               end else if (id_jal_valid && !stall && m_pend.size() == 0) begin
                  have = 1; tgt = id_pc + id_imm;
               end
               if (have) begin
`ifdef MISALIGN_TRAP_EN
                  if (tgt % 4 != 0) begin
                     tgt = TRAPV; e_trap = 1; is_ex = 1;
                  end
`else
                  tgt = tgt - (tgt % 4);
`endif
                  e_fif = 1; e_fid = is_ex;
                  m_pend.delete();
                  if (if_ready) m_pc = tgt;
                  else m_pend.push_back(tgt);
               end else if (m_pend.size() != 0) begin
                  if (if_ready) begin
                     m_pc  = m_pend.pop_front();
                     e_fif = 1;
                  end
               end else if (if_ready && !stall) begin
                  m_pc = m_pc + 32'd4;
               end
            end
            chk("m_flush_if", {31'd0, flush_if}, {31'd0, e_fif});
            chk("m_flush_id", {31'd0, flush_id}, {31'd0, e_fid});
            chk("m_trap", {31'd0, misalign_trap}, {31'd0, e_trap});
         end
      end
   end

   task automatic cyc(input bit rdy, input bit st, input bit jv,
                      input logic [31:0] ipc, input logic [31:0] imm,
                      input bit ev, input logic [31:0] et);
      @(posedge clk); #1;
      if_ready = rdy; stall = st; id_jal_valid = jv; id_pc = ipc; id_imm = imm;
      ex_redir_valid = ev; ex_target = et;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; if_ready = 1'b1; stall = 1'b0; id_jal_valid = 1'b0;
      id_pc = '0; id_imm = '0; ex_redir_valid = 1'b0; ex_target = '0;

      // Reset and boot
      @(negedge clk);
      @(negedge clk);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("boot_valid", {31'd0, if_valid}, 32'd0);
      cyc(1, 0, 0, 0, 0, 0, 0); chk("seq0", if_pc, 32'h0); chk("seq_valid", {31'd0, if_valid}, 32'd1);
      cyc(1, 0, 0, 0, 0, 0, 0); chk("seq4", if_pc, 32'h4);
      cyc(1, 0, 0, 0, 0, 0, 0); chk("seq8", if_pc, 32'h8);

      // JAL backward
      cyc(1, 0, 1, 32'h20, 32'hFFFF_FFF0, 0, 0);
      chk("jal_pc_before", if_pc, 32'hC);
      chk("jal_fif", {31'd0, flush_if}, 32'd1);
      chk("jal_fid", {31'd0, flush_id}, 32'd0);
      cyc(1, 0, 0, 0, 0, 0, 0); chk("jal_target", if_pc, 32'h10);

      // Execute over JAL
      cyc(1, 0, 1, 32'h20, 32'h100, 1, 32'h400);
      chk("ex_fif", {31'd0, flush_if}, 32'd1);
      chk("ex_fid", {31'd0, flush_id}, 32'd1);
      cyc(1, 0, 0, 0, 0, 0, 0); chk("ex_target", if_pc, 32'h400);

      // HOLD with overwrite
      cyc(0, 0, 1, 32'h70, 32'h10, 0, 0);
      chk("hold1_pc", if_pc, 32'h404); chk("hold1_fif", {31'd0, flush_if}, 32'd1);
      cyc(0, 0, 0, 0, 0, 1, 32'h200);
      chk("hold2_pc", if_pc, 32'h404); chk("hold2_fid", {31'd0, flush_id}, 32'd1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("hold3_pc", if_pc, 32'h404); chk("hold3_fif", {31'd0, flush_if}, 32'd1);
      chk("hold3_fid", {31'd0, flush_id}, 32'd0);
      cyc(1, 0, 0, 0, 0, 0, 0); chk("hold_release", if_pc, 32'h200);

      // Stall masks JAL, not execute redirects
      cyc(1, 1, 1, 32'h300, 32'h8, 0, 0);
      chk("stall1_pc", if_pc, 32'h204); chk("stall1_fif", {31'd0, flush_if}, 32'd0);
      cyc(1, 1, 1, 32'h300, 32'h8, 0, 0);
      chk("stall2_pc", if_pc, 32'h204); chk("stall2_fif", {31'd0, flush_if}, 32'd0);
      cyc(1, 0, 1, 32'h300, 32'h8, 0, 0);
      chk("stall3_pc", if_pc, 32'h204); chk("stall3_fif", {31'd0, flush_if}, 32'd1);
      cyc(1, 0, 0, 0, 0, 0, 0); chk("stall_jal", if_pc, 32'h308);
      cyc(1, 1, 0, 0, 0, 1, 32'h500);
      chk("stall_ex_pc", if_pc, 32'h30C); chk("stall_ex_fid", {31'd0, flush_id}, 32'd1);
      cyc(1, 0, 0, 0, 0, 0, 0); chk("stall_ex_target", if_pc, 32'h500);

      // Misaligned execute target
      cyc(1, 0, 0, 0, 0, 1, 32'h102);
      chk("mis_fid", {31'd0, flush_id}, 32'd1);
`ifdef MISALIGN_TRAP_EN
      chk("mis_trap", {31'd0, misalign_trap}, 32'd1);
`else
      chk("mis_trap", {31'd0, misalign_trap}, 32'd0);
`endif
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("mis_pc", if_pc, 32'h100);
      chk("mis_trap_off", {31'd0, misalign_trap}, 32'd0);

      // Reset while holding
      cyc(0, 0, 0, 0, 0, 1, 32'h800);
      chk("rh_fif", {31'd0, flush_if}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0; ex_redir_valid = 1'b0; if_ready = 1'b1;
      @(negedge clk);
      chk("rh_pc", if_pc, RST_PC); chk("rh_valid", {31'd0, if_valid}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk); chk("rh_boot", {31'd0, if_valid}, 32'd0);
      cyc(1, 0, 0, 0, 0, 0, 0); chk("rh_restart", if_pc, RST_PC);

      // Randomized traffic checked by the model
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         rst_n          = ($urandom_range(0, 249) != 0);
         if_ready       = ($urandom_range(0, 3) != 0);
         stall          = ($urandom_range(0, 4) == 0);
         id_jal_valid   = ($urandom_range(0, 5) == 0);
         id_pc          = $urandom & 32'hFFFF_FFFC;
         id_imm         = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFE)
                                                      : (32'($urandom_range(0, 255)) << 1);
         ex_redir_valid = ($urandom_range(0, 7) == 0);
         ex_target      = $urandom;
         if ($urandom_range(0, 1) != 0) ex_target = ex_target & 32'hFFFF_FFFC;
      end
      @(posedge clk); #1;
      rst_n = 1'b1; id_jal_valid = 1'b0; ex_redir_valid = 1'b0;
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
